// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmitter slice.
// Provides frame/sample geometry, the default bit-clock half-period,
// the packed stereo word layout and the per-slot serializer bit select.
package audio_pkg;

  localparam int unsigned FRAME_BITS        = 64;
  localparam int unsigned SAMPLE_W          = 16;
  localparam int unsigned BCLK_HALF_DEFAULT = 18;

  localparam int unsigned IDX_W  = $clog2(FRAME_BITS);
  localparam int unsigned SLOT_W = IDX_W - 1;
  localparam int unsigned SEL_W  = $clog2(SAMPLE_W);

  typedef logic [IDX_W-1:0] bit_idx_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } audio_word_t;

  // Bit driven on the data line for a given position in the frame.
  // Slot 0 of each half is the one-bclk I2S delay; slots past the sample are zero.
  function automatic logic slot_bit(input audio_word_t word, input bit_idx_t idx);
    logic [SAMPLE_W-1:0] chan;
    logic [SLOT_W-1:0]   h;
    logic [SEL_W-1:0]    pos;
    chan = (channel_e'(idx[IDX_W-1]) == CH_RIGHT) ? word.right : word.left;
    h    = idx[SLOT_W-1:0];
    pos  = SEL_W'(SAMPLE_W - 1) - SEL_W'(h - 1'b1);
    slot_bit = 1'b0;
    if (h != '0 && h <= SLOT_W'(SAMPLE_W)) begin
      slot_bit = chan[pos];
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio words between the push side and
// the frame-rate pop of the I2S serializer.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data
// (head, valid while !empty), full, empty, count (occupancy 0..DEPTH).
// A push while full is only accepted when a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count == (PTR_W + 1)'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: divides clk_in into bclk, walks a 64-slot frame and
// serializes one buffered stereo word per frame, MSB first, one bclk
// after each lrclk edge.
// Ports: clk_in, rst_in (sync, active-high), audio_in {left,right},
// audio_valid_in (push strobe), bclk_out, lrclk_out (0=left),
// sdata_out, word_taken_out (pop pulse at frame start), fifo_count_out,
// overflow_out / underflow_out (sticky until reset).
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_HALF  = BCLK_HALF_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [31:0]                   audio_in,
  input  logic                          audio_valid_in,
  output logic                          bclk_out,
  output logic                          lrclk_out,
  output logic                          sdata_out,
  output logic                          word_taken_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overflow_out,
  output logic                          underflow_out
);

  localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div;
  bit_idx_t         bit_idx;
  bit_idx_t         next_idx;
  audio_word_t      frame;
  audio_word_t      head;
  logic             div_wrap;
  logic             fall;
  logic             frame_start;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    div_wrap    = (div == DIV_W'(BCLK_HALF - 1));
    fall        = div_wrap && bclk_out;
    next_idx    = bit_idx + 1'b1;
    frame_start = fall && (next_idx == '0);
    push        = audio_valid_in && !rst_in;
    pop         = frame_start && !fifo_empty;
  end

  sample_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (audio_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_out)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div            <= '0;
      bclk_out       <= 1'b0;
      bit_idx        <= '1;
      lrclk_out      <= 1'b1;
      sdata_out      <= 1'b0;
      frame          <= '0;
      word_taken_out <= 1'b0;
      overflow_out   <= 1'b0;
      underflow_out  <= 1'b0;
    end else begin
      word_taken_out <= 1'b0;
      div            <= div_wrap ? '0 : div + 1'b1;
      if (div_wrap) bclk_out <= !bclk_out;

      // Slot 0 always drives zero, so the old frame register is safe to
      // use for the serializer even on the cycle the new word is loaded.
      if (fall) begin
        bit_idx   <= next_idx;
        lrclk_out <= next_idx[IDX_W-1];
        sdata_out <= slot_bit(frame, next_idx);
      end

      if (frame_start) begin
        if (pop) begin
          frame          <= head;
          word_taken_out <= 1'b1;
        end else begin
          frame         <= '0;
          underflow_out <= 1'b1;
        end
      end

      if (push && fifo_full && !pop) overflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
module tb_i2s_transmitter;

  localparam int BH = 18;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] audio = '0;
  logic        valid = 1'b0;
  logic        bclk, lrclk, sdata, taken, ovf, unf;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  i2s_transmitter #(.BCLK_HALF(BH), .FIFO_DEPTH(FD)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .audio_in       (audio),
    .audio_valid_in (valid),
    .bclk_out       (bclk),
    .lrclk_out      (lrclk),
    .sdata_out      (sdata),
    .word_taken_out (taken),
    .fifo_count_out (count),
    .overflow_out   (ovf),
    .underflow_out  (unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // lrclk/sdata may only change in the cycle where bclk falls
  logic rst_q = 1'b1;
  bit   mon_on = 1'b0;
  logic m_pb, m_pl, m_ps;
  always @(posedge clk) rst_q <= rst;
  always @(negedge clk) begin
    if (mon_on && !rst_q && (lrclk !== m_pl || sdata !== m_ps)) begin
      checks++;
      if (!(m_pb === 1'b1 && bclk === 1'b0)) begin
        failures++;
        $display("FAIL edge_align t=%0t lrclk=%b sdata=%b bclk_prev=%b bclk=%b want change only on bclk fall",
                 $time, lrclk, sdata, m_pb, bclk);
      end
    end
    m_pb = bclk; m_pl = lrclk; m_ps = sdata;
  end

  function automatic logic [63:0] exp_frame(input logic [31:0] w);
    return {1'b0, w[31:16], 15'd0, 1'b0, w[15:0], 15'd0};
  endfunction

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; mon_on = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    audio = w; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Waits for the next frame start (bclk fall with lrclk 1->0), then records
  // sdata at 64 consecutive falls; bits[63] is slot 0 of the left half.
  task automatic capture_frame(output logic [63:0] bits, output int ntaken, output bit ok);
    int   guard = 0;
    int   falls = 0;
    bit   found = 0;
    logic pb, pl;
    bits = '0; ntaken = 0; ok = 0;
    pb = bclk; pl = lrclk;
    while (!found && guard < 3000) begin
      @(negedge clk); guard++;
      if (pb && !bclk && pl && !lrclk) found = 1;
      pb = bclk; pl = lrclk;
    end
    if (found) begin
      bits[63] = sdata; ntaken += int'(taken); falls = 1;
      while (falls < 64 && guard < 6000) begin
        @(negedge clk); guard++;
        ntaken += int'(taken);
        if (pb && !bclk) begin bits[63-falls] = sdata; falls++; end
        pb = bclk;
      end
      ok = (falls == 64);
    end
  endtask

  task automatic test_reset();
    int   n = 0;
    logic pb;
    rst = 1'b1; audio = 32'hDEAD_BEEF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; rst = 1'b0; mon_on = 1'b1;
    checks++; if (bclk !== 1'b0)  begin failures++; $display("FAIL rst_bclk got=%b want=0", bclk); end
    checks++; if (lrclk !== 1'b1) begin failures++; $display("FAIL rst_lrclk got=%b want=1", lrclk); end
    checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL rst_sdata got=%b want=0", sdata); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d want=0", count); end
    checks++; if (taken !== 1'b0) begin failures++; $display("FAIL rst_taken got=%b want=0", taken); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL rst_ovf got=%b want=0", ovf); end
    checks++; if (unf !== 1'b0)   begin failures++; $display("FAIL rst_unf got=%b want=0", unf); end
    pb = bclk;
    while (n < 200) begin
      @(negedge clk); n++;
      if (pb && !bclk) break;
      pb = bclk;
    end
    checks++; if (n !== 2*BH) begin failures++; $display("FAIL first_fall_latency got=%0d want=%0d", n, 2*BH); end
    checks++; if (lrclk !== 1'b0) begin failures++; $display("FAIL first_fall_lrclk got=%b want=0", lrclk); end
    checks++; if (unf !== 1'b1)   begin failures++; $display("FAIL rst_push_ignored_unf got=%b want=1", unf); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_push_ignored_count got=%0d want=0", count); end
  endtask

  task automatic test_single_word();
    logic [63:0] bits; int nt; bit ok;
    do_reset();
    push_word(32'hA5A5_1234);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d want=1", count); end
    capture_frame(bits, nt, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_capture got=timeout want=frame"); end
    checks++; if (bits !== exp_frame(32'hA5A5_1234)) begin failures++;
      $display("FAIL single_bits got=%h want=%h", bits, exp_frame(32'hA5A5_1234)); end
    checks++; if (nt !== 1) begin failures++; $display("FAIL single_taken got=%0d want=1", nt); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count_after got=%0d want=0", count); end
    checks++; if (unf !== 1'b0) begin failures++; $display("FAIL single_unf got=%b want=0", unf); end
  endtask

  // use_lr=0: wait for bclk rise; use_lr=1: wait for lrclk fall
  task automatic wait_sig_edge(input bit use_lr, input int limit, output int at, output bit ok);
    logic p, s;
    p = use_lr ? lrclk : bclk; ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      s = use_lr ? lrclk : bclk;
      if (use_lr ? (p && !s) : (!p && s)) begin ok = 1; at = cyc; break; end
      p = s;
    end
  endtask

  task automatic test_timing();
    int a, b, c; bit ok1, ok2, ok3;
    wait_sig_edge(1'b0, 100, a, ok1);
    wait_sig_edge(1'b0, 100, b, ok2);
    wait_sig_edge(1'b0, 100, c, ok3);
    checks++; if (!(ok1 && ok2 && ok3) || (b - a) != 2*BH) begin failures++;
      $display("FAIL bclk_period got=%0d want=%0d", b - a, 2*BH); end
    checks++; if (!(ok2 && ok3) || (c - b) != 2*BH) begin failures++;
      $display("FAIL bclk_period2 got=%0d want=%0d", c - b, 2*BH); end
    wait_sig_edge(1'b1, 3000, a, ok1);
    wait_sig_edge(1'b1, 3000, b, ok2);
    checks++; if (!(ok1 && ok2) || (b - a) != 128*BH) begin failures++;
      $display("FAIL lrclk_period got=%0d want=%0d", b - a, 128*BH); end
  endtask

  task automatic test_underflow();
    logic [63:0] bits; int nt; bit ok;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      capture_frame(bits, nt, ok);
      checks++; if (!ok || bits !== 64'd0) begin failures++;
        $display("FAIL underflow_bits frame=%0d got=%h ok=%0d want=0", f, bits, ok); end
      checks++; if (nt !== 0) begin failures++; $display("FAIL underflow_taken frame=%0d got=%0d want=0", f, nt); end
      checks++; if (unf !== 1'b1) begin failures++; $display("FAIL underflow_flag frame=%0d got=%b want=1", f, unf); end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] bits; int nt; bit ok;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      push_word(32'(i));
      if (i == 4) begin
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%b want=0", ovf); end
      end
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d want=4", count); end
    checks++; if (ovf !== 1'b1)   begin failures++; $display("FAIL ovf_flag got=%b want=1", ovf); end
    for (int i = 1; i <= 4; i++) begin
      capture_frame(bits, nt, ok);
      checks++; if (!ok || bits !== exp_frame(32'(i)) || nt !== 1) begin failures++;
        $display("FAIL ovf_frame%0d got=%h taken=%0d want=%h taken=1", i, bits, nt, exp_frame(32'(i))); end
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL ovf_drain_count got=%0d want=0", count); end
  endtask

  task automatic test_full_pop();
    logic [31:0] w [5];
    logic [63:0] bits; int nt; bit ok;
    w[0] = 32'h8001_7FFE; w[1] = 32'h1234_5678; w[2] = 32'hFFFF_0000;
    w[3] = 32'h0F0F_F0F0; w[4] = 32'hC3C3_3C3C;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(w[i]);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_fill got=%0d want=4", count); end
    // first frame-start pop lands on edge 2*BH after reset release; 4 edges used so far
    repeat (2*BH - 5) @(negedge clk);
    push_word(w[4]);
    checks++; if (taken !== 1'b1) begin failures++; $display("FAIL fullpop_taken got=%b want=1", taken); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_count got=%0d want=4", count); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL fullpop_ovf got=%b want=0", ovf); end
    for (int i = 1; i < 5; i++) begin
      capture_frame(bits, nt, ok);
      checks++; if (!ok || bits !== exp_frame(w[i]) || nt !== 1) begin failures++;
        $display("FAIL fullpop_frame%0d got=%h taken=%0d want=%h taken=1", i, bits, nt, exp_frame(w[i])); end
    end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin failures++;
      $display("FAIL fullpop_flags got=ovf%b unf%b want=ovf0 unf0", ovf, unf); end
  endtask

  task automatic test_midframe_reset();
    logic [63:0] bits; int nt; bit ok;
    int   guard = 0;
    int   falls = -1;
    logic pb, pl;
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'hFFFF_FFFF);
    pb = bclk; pl = lrclk;
    while (falls < 40 && guard < 5000) begin
      @(negedge clk); guard++;
      if (falls < 0 && pb && !bclk && pl && !lrclk) falls = 0;
      else if (falls >= 0 && pb && !bclk) falls++;
      pb = bclk; pl = lrclk;
    end
    checks++; if (falls !== 40) begin failures++; $display("FAIL mid_reach_idx40 got=%0d want=40", falls); end
    checks++; if (lrclk !== 1'b1 || sdata !== 1'b1) begin failures++;
      $display("FAIL mid_pre_state got=lr%b sd%b want=lr1 sd1", lrclk, sdata); end
    checks++; if (count !== 3'd3 || ovf !== 1'b1) begin failures++;
      $display("FAIL mid_pre_fifo got=cnt%0d ovf%b want=cnt3 ovf1", count, ovf); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bclk, lrclk, sdata, taken, ovf, unf} !== 6'b010000) begin failures++;
      $display("FAIL mid_reset_outs got=%b want=010000", {bclk, lrclk, sdata, taken, ovf, unf}); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_reset_count got=%0d want=0", count); end
    capture_frame(bits, nt, ok);
    checks++; if (!ok || bits !== 64'd0 || nt !== 0) begin failures++;
      $display("FAIL mid_after_frame got=%h taken=%0d want=0 taken=0", bits, nt); end
    checks++; if (unf !== 1'b1) begin failures++; $display("FAIL mid_after_unf got=%b want=1", unf); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_timing();
    test_underflow();
    test_overflow();
    test_full_pop();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
